st_sink_checker: RTL and testbench
==================================

Name: st_sink_checker

Overview:
- Parametrised successor to the msgdma stream sink. Terminates the F2H streaming source (msgdma_0_st_source) in the fabric.
- Generates a programmable ready/backpressure pattern.
- Checks every accepted beat against an incrementing-word pattern and exposes beat, error and first-error status.
- Control and status are flat ports, driven by the h2f bridge register logic in system_top_level.

Parameters:
- DATA_WIDTH, 256, stream beat width in bits; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32, pattern word width in bits.
- CNT_WIDTH, 32, width of the beat and error counters.
- THR_WIDTH, 8, width of the throttle period field.

Ports:
- clk  in  1  system clock (FPGA_CLK1_50 domain).
- rst_n  in  1  asynchronous active-low reset.
- st_data  in  DATA_WIDTH  stream data.
- valid  in  1  stream valid.
- ready  out  1  stream ready, registered.
- enable  in  1  checker enable; low forces ready=0.
- mode  in  2  backpressure mode: 0 ALWAYS, 1 PERIODIC, 2 RANDOM, 3 STALL.
- throttle_period  in  THR_WIDTH  PERIODIC period minus 1.
- clear  in  1  single-cycle sync clear of all status.
- locked  out  1  base value captured from the first beat.
- beat_count  out  CNT_WIDTH  accepted beats since clear, saturating.
- err_count  out  CNT_WIDTH  mismatching beats, saturating.
- err_seen  out  1  sticky, set on the first mismatch.
- first_err_beat  out  CNT_WIDTH  beat index of the first mismatch.
- first_err_mask  out  DATA_WIDTH/WORD_WIDTH  per-word mismatch mask of the first error.

Behaviour:
- NW = DATA_WIDTH/WORD_WIDTH. Word i sits at bits [i*WORD_WIDTH +: WORD_WIDTH].
- Accept: valid && ready in the same cycle; readyLatency 0. valid without ready is held by the source and ignored.
- Reset: ready=0, locked=0, all counters/masks 0, err_seen=0, throttle counter 0, LFSR=16'hACE1.
- ready generation (registered, takes effect the cycle after a mode/enable change):
  - ALWAYS: ready = enable.
  - PERIODIC: counter counts 0..throttle_period and wraps; ready = enable && counter==0. throttle_period=0 is equivalent to ALWAYS.
  - RANDOM: 16-bit Fibonacci LFSR, taps 16,14,13,11, steps every cycle; ready = enable && lfsr[0].
  - STALL: ready = 0.
- Pattern:
  - The first accepted beat after reset or clear sets base = word0 and locked=1.
  - That beat is checked with its own base, so it matches only if its words are base+i.
  - Beat k (0-based since lock) expects word i = base + k*NW + i, modulo 2^WORD_WIDTH; wrap-around is legal.
- Pipeline:
  - Stage 1 registers the accepted data and the expected word0.
  - Stage 2 registers the per-word compare mask.
  - Counters and status update 2 cycles after acceptance. One beat per cycle sustained; no stalls inside the checker.
- Error:
  - A mask that is non-zero increments err_count.
  - If err_seen=0: set err_seen, latch first_err_beat = k and first_err_mask.
  - The expected sequence continues from the lock, not from the bad data; no resync.
- Counters saturate at all-ones; no wrap.
- clear:
  - Zeroes counters, masks and err_seen, drops locked, and flushes both pipeline stages.
  - A beat accepted in the same cycle as clear is discarded from statistics; the next accepted beat re-locks.
  - clear does not affect ready, the throttle counter or the LFSR.
- enable deassert mid-stream: ready drops the next cycle. Beats already in the pipeline still complete; lock and expected index are kept.
- Reset asserted mid-operation clears everything asynchronously; ready is 0 until the first clk edge after release.

Decomposition:
- Package st_chk_pkg holds:
  - enum bp_mode_e {BP_ALWAYS, BP_PERIODIC, BP_RANDOM, BP_STALL};
  - localparam LFSR_SEED = 16'hACE1 and the tap mask;
  - function num_words(dw, ww).
- Sub-module st_ready_gen holds the mode mux, throttle counter and LFSR, and outputs registered ready.
- Compare and counters stay in st_sink_checker.

Test Plan:
- Reset, mode=0, enable=1, 16 beats with words 100+8k+i back to back -> ready=1 throughout, beat_count=16, err_count=0, locked=1, err_seen=0.
- mode=1, throttle_period=3, valid held high -> ready high 1 cycle in 4; after 40 cycles beat_count=10, no errors.
- Correct stream; in beat 5 corrupt word 2 and word 7 -> err_count=1, err_seen=1, first_err_beat=5, first_err_mask=8'b1000_0100; beat 6 correct -> err_count stays 1.
- base=32'hFFFF_FFF8, 3 beats -> word wrap to 0 handled, err_count=0; then clear pulse coincident with an accept -> beat_count=0, locked=0; next beat with base 7 re-locks, beat_count=1.
- mode=2 with constant valid over 1000 cycles -> ready matches a reference LFSR model cycle-for-cycle, beat_count equals the count of ready cycles; mode=3 -> ready=0, counts frozen.
- Assert rst_n low during a burst -> all outputs 0 immediately; after release, the first beat re-locks.

Source files
------------

// File: rtl/st_chk_pkg.sv
// Shared types and constants for the streaming sink checker.
package st_chk_pkg;

    typedef enum logic [1:0] {
        BP_ALWAYS   = 2'd0,
        BP_PERIODIC = 2'd1,
        BP_RANDOM   = 2'd2,
        BP_STALL    = 2'd3
    } bp_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int unsigned num_words(input int unsigned dw, input int unsigned ww);
        return dw / ww;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/st_sink_checker_ready_gen.sv
// Backpressure pattern generator: mode mux, throttle counter, LFSR, registered ready.
module st_ready_gen
    import st_chk_pkg::*;
#(
    parameter int unsigned THR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [THR_WIDTH-1:0] throttle_period,
    output logic                 ready
);

    bp_mode_e             mode_e;
    logic [THR_WIDTH-1:0] thr_cnt;
    logic [THR_WIDTH-1:0] thr_cnt_nxt;
    logic [15:0]          lfsr;
    logic                 ready_nxt;

    assign mode_e = bp_mode_e'(mode);

    // Next ready value and throttle count for the selected mode.
    always_comb begin
        ready_nxt   = 1'b0;
        thr_cnt_nxt = '0;
        case (mode_e)
            BP_ALWAYS: begin
                ready_nxt = enable;
            end
            BP_PERIODIC: begin
                ready_nxt   = enable && (thr_cnt == '0);
                thr_cnt_nxt = (thr_cnt >= throttle_period) ? '0 : thr_cnt + THR_WIDTH'(1);
            end
            BP_RANDOM: begin
                ready_nxt = enable && lfsr[0];
            end
            default: begin
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Ready, throttle counter and free-running LFSR registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready   <= 1'b0;
            thr_cnt <= '0;
            lfsr    <= LFSR_SEED;
        end else begin
            ready   <= ready_nxt;
            thr_cnt <= thr_cnt_nxt;
            lfsr    <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/st_sink_checker.sv
// Stream sink: programmable backpressure plus incrementing-word pattern checker.
module st_sink_checker
    import st_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned THR_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            st_data,
    input  logic                             valid,
    output logic                             ready,
    input  logic                             enable,
    input  logic [1:0]                       mode,
    input  logic [THR_WIDTH-1:0]             throttle_period,
    input  logic                             clear,
    output logic                             locked,
    output logic [CNT_WIDTH-1:0]             beat_count,
    output logic [CNT_WIDTH-1:0]             err_count,
    output logic                             err_seen,
    output logic [CNT_WIDTH-1:0]             first_err_beat,
    output logic [DATA_WIDTH/WORD_WIDTH-1:0] first_err_mask
);

    localparam int unsigned NW = num_words(DATA_WIDTH, WORD_WIDTH);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic                  accept;
    logic [WORD_WIDTH-1:0] exp_next;
    logic [CNT_WIDTH-1:0]  acc_idx;
    logic [WORD_WIDTH-1:0] cur_exp0;
    logic [CNT_WIDTH-1:0]  cur_idx;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [WORD_WIDTH-1:0] s1_exp0;
    logic [CNT_WIDTH-1:0]  s1_idx;
    logic [NW-1:0]         cmp_mask;

    logic                  s2_valid;
    logic [NW-1:0]         s2_mask;
    logic [CNT_WIDTH-1:0]  s2_idx;

    st_ready_gen #(
        .THR_WIDTH(THR_WIDTH)
    ) u_ready_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .mode           (mode),
        .throttle_period(throttle_period),
        .ready          (ready)
    );

    assign accept = valid && ready;

    // Expected word0 and beat index for the beat on the bus; an unlocked beat is its own base.
    always_comb begin
        cur_exp0 = st_data[WORD_WIDTH-1:0];
        cur_idx  = '0;
        if (locked) begin
            cur_exp0 = exp_next;
            cur_idx  = acc_idx;
        end
    end

    // Lock state and running expectation, advanced once per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            exp_next <= '0;
            acc_idx  <= '0;
        end else if (clear) begin
            locked   <= 1'b0;
            exp_next <= '0;
            acc_idx  <= '0;
        end else if (accept) begin
            locked   <= 1'b1;
            exp_next <= cur_exp0 + WORD_WIDTH'(NW);
            acc_idx  <= sat_inc(cur_idx);
        end
    end

    // Stage 1: capture accepted data with its expected word0 and index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_exp0  <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept && !clear;
            if (accept) begin
                s1_data <= st_data;
                s1_exp0 <= cur_exp0;
                s1_idx  <= cur_idx;
            end
        end
    end

    // Per-word comparison of the stage-1 beat against exp0 + i.
    always_comb begin
        cmp_mask = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (s1_data[i*WORD_WIDTH +: WORD_WIDTH] != s1_exp0 + WORD_WIDTH'(i)) begin
                cmp_mask[i] = 1'b1;
            end
        end
    end

    // Stage 2: register the compare mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mask  <= '0;
            s2_idx   <= '0;
        end else begin
            s2_valid <= s1_valid && !clear;
            if (s1_valid) begin
                s2_mask <= cmp_mask;
                s2_idx  <= s1_idx;
            end
        end
    end

    // Saturating statistics and first-error capture from stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count     <= '0;
            err_count      <= '0;
            err_seen       <= 1'b0;
            first_err_beat <= '0;
            first_err_mask <= '0;
        end else if (clear) begin
            beat_count     <= '0;
            err_count      <= '0;
            err_seen       <= 1'b0;
            first_err_beat <= '0;
            first_err_mask <= '0;
        end else if (s2_valid) begin
            beat_count <= sat_inc(beat_count);
            if (|s2_mask) begin
                err_count <= sat_inc(err_count);
                if (!err_seen) begin
                    err_seen       <= 1'b1;
                    first_err_beat <= s2_idx;
                    first_err_mask <= s2_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_st_sink_checker.sv
// Self-checking bench for st_sink_checker: directed table, corner sequences, randomized run.
`timescale 1ns/1ps
module tb_st_sink_checker;

    localparam int unsigned DW = 256;
    localparam int unsigned WW = 32;
    localparam int unsigned CW = 32;
    localparam int unsigned TW = 8;
    localparam int unsigned NW = DW / WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] st_data = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          enable = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [TW-1:0] throttle_period = '0;
    logic          clear = 1'b0;
    logic          locked;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] err_count;
    logic          err_seen;
    logic [CW-1:0] first_err_beat;
    logic [NW-1:0] first_err_mask;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    st_sink_checker #(
        .DATA_WIDTH(DW),
        .WORD_WIDTH(WW),
        .CNT_WIDTH (CW),
        .THR_WIDTH (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .st_data        (st_data),
        .valid          (valid),
        .ready          (ready),
        .enable         (enable),
        .mode           (mode),
        .throttle_period(throttle_period),
        .clear          (clear),
        .locked         (locked),
        .beat_count     (beat_count),
        .err_count      (err_count),
        .err_seen       (err_seen),
        .first_err_beat (first_err_beat),
        .first_err_mask (first_err_mask)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] b, input int unsigned k,
                                         input logic [NW-1:0] cm);
        logic [DW-1:0] d;
        logic [31:0]   w;
        d = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            w = b + 32'(k * NW + i);
            if (cm[i]) w = w ^ 32'h0100_0001;
            d[i*WW +: WW] = w;
        end
        return d;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [NW-1:0] mask;
        int unsigned   k;
    } pend_t;

    pend_t         pend[$];
    logic          m_ready;
    int unsigned   m_tcnt;
    logic [15:0]   m_lfsr;
    logic          m_locked;
    logic [31:0]   m_base;
    int unsigned   m_k;
    int            cyc;
    logic [31:0]   m_beats, m_errs, m_fbeat;
    logic          m_seen;
    logic [NW-1:0] m_fmask;
    logic          m_acc, m_nr, m_fb;
    logic [NW-1:0] m_mask;
    logic [31:0]   m_exp;
    pend_t         m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1'b0; m_tcnt = 0; m_lfsr = 16'hACE1;
            m_locked = 1'b0; m_base = '0; m_k = 0; cyc = 0;
            m_beats = '0; m_errs = '0; m_fbeat = '0; m_seen = 1'b0; m_fmask = '0;
            pend.delete();
        end else begin
            m_acc = valid && m_ready;
            case (mode)
                2'd0:    m_nr = enable;
                2'd1:    m_nr = enable && (m_tcnt == 0);
                2'd2:    m_nr = enable && m_lfsr[0];
                default: m_nr = 1'b0;
            endcase
            if (mode == 2'd1) m_tcnt = (m_tcnt + 1) % (int'(throttle_period) + 1);
            else m_tcnt = 0;
            m_fb   = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {m_fb, m_lfsr[15:1]};
            m_ready = m_nr;
            cyc++;
            if (clear) begin
                m_locked = 1'b0; m_k = 0;
                m_beats = '0; m_errs = '0; m_fbeat = '0; m_seen = 1'b0; m_fmask = '0;
                pend.delete();
            end else begin
                while (pend.size() > 0 && pend[0].due <= cyc) begin
                    m_p = pend.pop_front();
                    m_beats++;
                    if (m_p.mask != 0) begin
                        m_errs++;
                        if (!m_seen) begin
                            m_seen = 1'b1; m_fbeat = m_p.k; m_fmask = m_p.mask;
                        end
                    end
                end
                if (m_acc) begin
                    if (!m_locked) begin
                        m_base = st_data[31:0]; m_locked = 1'b1; m_k = 0;
                    end
                    for (int unsigned i = 0; i < NW; i++) begin
                        m_exp = m_base + 32'(m_k * NW + i);
                        m_mask[i] = (st_data[i*WW +: WW] != m_exp);
                    end
                    m_p.due = cyc + 2; m_p.mask = m_mask; m_p.k = m_k;
                    pend.push_back(m_p);
                    m_k++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("ready",      ready,          m_ready);
            chk("locked",     locked,         m_locked);
            chk("beat_count", beat_count,     m_beats);
            chk("err_count",  err_count,      m_errs);
            chk("err_seen",   err_seen,       m_seen);
            chk("first_beat", first_err_beat, m_fbeat);
            chk("first_mask", first_err_mask, m_fmask);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        string         name;
        logic [1:0]    mode;
        logic [TW-1:0] period;
        int unsigned   cycles;
        int unsigned   max_beats;
        logic [31:0]   base;
        int            corrupt_k;
        logic [NW-1:0] corrupt_mask;
        logic [31:0]   e_beats;
        logic [31:0]   e_errs;
        logic          e_seen;
        logic [31:0]   e_fbeat;
        logic [NW-1:0] e_fmask;
        logic          e_locked;
    } vec_t;

    vec_t        vt[6];
    int unsigned dk;
    logic [31:0] dbase;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned ncyc, input int unsigned upto,
                         input int ck, input logic [NW-1:0] cm);
        logic r;
        for (int unsigned c = 0; c < ncyc && dk < upto; c++) begin
            valid   = 1'b1;
            st_data = mk(dbase, dk, (int'(dk) == ck) ? cm : '0);
            r       = ready;
            tick();
            if (r) dk++;
        end
    endtask

    task automatic clear_pulse(input logic [1:0] md, input logic [TW-1:0] per);
        valid = 1'b0; mode = md; throttle_period = per; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain();
        valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},  ready,          0);
        chk({tag, "_locked"}, locked,         0);
        chk({tag, "_beats"},  beat_count,     0);
        chk({tag, "_errs"},   err_count,      0);
        chk({tag, "_seen"},   err_seen,       0);
        chk({tag, "_fbeat"},  first_err_beat, 0);
        chk({tag, "_fmask"},  first_err_mask, 0);
    endtask

    initial begin
        int unsigned nready;
        logic [NW-1:0] cm;
        logic r;

        vt[0] = '{"always16", 2'd0, 8'd0, 40, 16, 32'd100, -1, 8'h00, 16, 0, 1'b0, 0, 8'h00, 1'b1};
        vt[1] = '{"periodic", 2'd1, 8'd3, 40, 1000, 32'd0, -1, 8'h00, 10, 0, 1'b0, 0, 8'h00, 1'b1};
        vt[2] = '{"err_b5",   2'd0, 8'd0, 40, 8, 32'h1000, 5, 8'h84, 8, 1, 1'b1, 5, 8'h84, 1'b1};
        vt[3] = '{"err_b0",   2'd0, 8'd0, 40, 4, 32'h3000, 0, 8'h08, 4, 1, 1'b1, 0, 8'h08, 1'b1};
        vt[4] = '{"stall",    2'd3, 8'd0, 20, 1000, 32'd0, -1, 8'h00, 0, 0, 1'b0, 0, 8'h00, 1'b0};
        vt[5] = '{"wrap",     2'd0, 8'd0, 40, 3, 32'hFFFF_FFF8, -1, 8'h00, 3, 0, 1'b0, 0, 8'h00, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();

        for (int v = 0; v < 6; v++) begin
            clear_pulse(vt[v].mode, vt[v].period);
            dk = 0; dbase = vt[v].base;
            drive(vt[v].cycles, vt[v].max_beats, vt[v].corrupt_k, vt[v].corrupt_mask);
            drain();
            chk({vt[v].name, "_beats"},  beat_count,     vt[v].e_beats);
            chk({vt[v].name, "_errs"},   err_count,      vt[v].e_errs);
            chk({vt[v].name, "_seen"},   err_seen,       vt[v].e_seen);
            chk({vt[v].name, "_fbeat"},  first_err_beat, vt[v].e_fbeat);
            chk({vt[v].name, "_fmask"},  first_err_mask, vt[v].e_fmask);
            chk({vt[v].name, "_locked"}, locked,         vt[v].e_locked);
        end

        // clear coincident with an accepted beat, then relock on base 7
        valid = 1'b1; st_data = mk(32'hFFFF_FFF8, 3, '0); clear = 1'b1;
        tick();
        clear = 1'b0;
        drain();
        chk("clracc_beats",  beat_count, 0);
        chk("clracc_locked", locked,     0);
        dk = 0; dbase = 32'd7;
        drive(5, 1, -1, '0);
        drain();
        chk("relock_beats",  beat_count, 1);
        chk("relock_locked", locked,     1);
        chk("relock_errs",   err_count,  0);

        // enable dropped mid-stream keeps lock and index
        clear_pulse(2'd0, '0);
        dk = 0; dbase = 32'h2000;
        drive(10, 4, -1, '0);
        enable = 1'b0;
        drive(6, 100, -1, '0);
        enable = 1'b1;
        drive(20, 8, -1, '0);
        drain();
        chk("en_beats", beat_count, 8);
        chk("en_errs",  err_count,  0);

        // RANDOM backpressure, then STALL freezes counts
        clear_pulse(2'd2, '0);
        dk = 0; dbase = 32'h0ABC_0000; nready = 0;
        for (int c = 0; c < 1000; c++) begin
            valid = 1'b1; st_data = mk(dbase, dk, '0); r = ready;
            tick();
            if (r) begin dk++; nready++; end
        end
        valid = 1'b0; mode = 2'd3;
        tick();
        drain();
        chk("rand_beats", beat_count, nready);
        chk("rand_errs",  err_count,  0);
        for (int c = 0; c < 50; c++) begin
            valid = 1'b1; st_data = mk(dbase, dk, '0);
            tick();
        end
        drain();
        chk("stall_beats", beat_count, nready);

        // asynchronous reset during a burst
        clear_pulse(2'd0, '0);
        dk = 0; dbase = 32'h500;
        drive(5, 3, -1, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rel_ready", ready, 0);
        tick();
        dk = 0; dbase = 32'd50;
        drive(5, 1, -1, '0);
        drain();
        chk("postrst_locked", locked,     1);
        chk("postrst_beats",  beat_count, 1);
        chk("postrst_errs",   err_count,  0);

        // randomized traffic against the model
        dk = 0; dbase = $urandom();
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                clear = 1'b0; valid = 1'b0; mode = 2'd0;
                throttle_period = TW'($urandom_range(0, 5));
                tick();
                mode = 2'($urandom_range(0, 3));
            end
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 99) == 0);
            valid  = ($urandom_range(0, 9) < 7);
            cm = '0;
            if ($urandom_range(0, 19) == 0) cm[$urandom_range(0, NW-1)] = 1'b1;
            st_data = mk(dbase, dk, cm);
            r = ready;
            tick();
            if (clear) begin
                dk = 0; dbase = $urandom();
            end else if (r && valid) begin
                dk++;
            end
        end
        clear = 1'b0; enable = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        n_miss++;
        $display("FAIL timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
